// File: rtl/if_id_pkg.sv
// ============================================================================
// Module   : if_id_pkg
// Brief    : Shared widths, NOP encoding and entry type for the IF/ID buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_id_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_id_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_id_entry_mem.sv
// ============================================================================
// Module   : if_id_entry_mem
// Brief    : DEPTH-entry register array, one write port, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_entry_mem
  import if_id_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  if_id_entry_t  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output if_id_entry_t  rdata_o
);

  // Contents are not reset; validity is tracked by the owner's occupancy count.
  if_id_entry_t r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

`default_nettype wire

// File: rtl/if_id_buffer.sv
// ============================================================================
// Module   : if_id_buffer
// Brief    : FIFO instruction buffer between IF and ID with flush and NOP fill.
//            Optional IF_ID_BUF_PERF_EN adds bubble/full cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_buffer
  import if_id_pkg::*;
#(
  parameter int PC_W     = if_id_pkg::PC_W,
  parameter int INSTR_W  = if_id_pkg::INSTR_W,
  parameter int DEPTH    = 2,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [CNT_W-1:0]   count_o
`ifdef IF_ID_BUF_PERF_EN
  ,
  output logic [31:0]        bubble_cnt_o,
  output logic [31:0]        full_cnt_o
`endif
);

  localparam int               c_ptr_w = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_full  = CNT_W'(DEPTH);

  logic [c_ptr_w-1:0] r_wp;
  logic [c_ptr_w-1:0] r_rp;
  logic [CNT_W-1:0]   r_cnt;

  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic         w_in_ready;
  logic         w_out_valid;
  if_id_entry_t w_wdata;
  if_id_entry_t w_rdata;

  // Ready depends on held occupancy only, so a full buffer refuses even while popping.
  assign w_in_ready  = (r_cnt != c_full);
  assign w_out_valid = (r_cnt != '0);
  assign w_flush     = start_i & flush_i;
  assign w_push      = start_i & in_valid_i & w_in_ready & ~flush_i;
  assign w_pop       = start_i & w_out_valid & out_ready_i & ~stall_i & ~flush_i;

  assign w_wdata.pc    = pc_i;
  assign w_wdata.instr = instr_i;

  if_id_entry_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_push),
    .waddr_i (r_wp),
    .wdata_i (w_wdata),
    .raddr_i (r_rp),
    .rdata_o (w_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (w_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + c_ptr_w'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign pc_o        = w_out_valid ? w_rdata.pc    : '0;
  assign instr_o     = w_out_valid ? w_rdata.instr : NOP_INSTR;
  assign count_o     = r_cnt;

`ifdef IF_ID_BUF_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_full_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bubble_cnt <= '0;
      r_full_cnt   <= '0;
    end else begin
      if (start_i && !w_out_valid && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
      if (start_i && in_valid_i && !w_in_ready && (r_full_cnt != '1)) begin
        r_full_cnt <= r_full_cnt + 32'd1;
      end
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
  assign full_cnt_o   = r_full_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_buffer.sv
// ============================================================================
// Module   : tb_if_id_buffer
// Brief    : Directed self-checking bench for if_id_buffer (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [1:0]  count_o;
`ifdef IF_ID_BUF_PERF_EN
  logic [31:0] bubble_cnt_o;
  logic [31:0] full_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  if_id_buffer #(
    .PC_W    (32),
    .INSTR_W (32),
    .DEPTH   (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .pc_i        (pc_i),
    .instr_i     (instr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .pc_o        (pc_o),
    .instr_o     (instr_o),
    .count_o     (count_o)
`ifdef IF_ID_BUF_PERF_EN
    ,
    .bubble_cnt_o (bubble_cnt_o),
    .full_cnt_o   (full_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    in_valid_i = v;
    pc_i       = pc;
    instr_i    = ins;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; out_ready_i = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step(); step();
    rst_i = 1'b0;
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_ready", 64'(in_ready_o), 64'd1);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_pc", 64'(pc_o), 64'd0);
    check("rst_instr", 64'(instr_o), 64'd0);

    // Single push, visible one cycle later
    start_i = 1'b1;
    drive(1'b1, 32'h4, 32'h00500093);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("p1_valid", 64'(out_valid_o), 64'd1);
    check("p1_pc", 64'(pc_o), 64'h4);
    check("p1_instr", 64'(instr_o), 64'h00500093);
    check("p1_count", 64'(count_o), 64'd1);

    // Fill to DEPTH, third push held off until a pop
    drive(1'b1, 32'h8, 32'h00800113);
    step();
    check("full_count", 64'(count_o), 64'd2);
    check("full_ready", 64'(in_ready_o), 64'd0);
    drive(1'b1, 32'hC, 32'h00C00193);
    step();
    check("hold_count", 64'(count_o), 64'd2);
    check("hold_pc", 64'(pc_o), 64'h4);
    out_ready_i = 1'b1;
    step();
    check("pop_full_count", 64'(count_o), 64'd1);
    check("pop_full_pc", 64'(pc_o), 64'h8);
    check("pop_full_ready", 64'(in_ready_o), 64'd1);
    step();
    check("third_count", 64'(count_o), 64'd1);
    check("third_pc", 64'(pc_o), 64'hC);
    check("third_instr", 64'(instr_o), 64'h00C00193);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("drain_count", 64'(count_o), 64'd0);
    check("drain_valid", 64'(out_valid_o), 64'd0);

    // Streaming push+pop at cnt=1 across pointer wrap
    out_ready_i = 1'b0;
    drive(1'b1, 32'h100, 32'h1000);
    step();
    out_ready_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
      step();
      check("stream_count", 64'(count_o), 64'd1);
      check("stream_pc", 64'(pc_o), 64'(32'h100 + 32'(4 * i)));
    end
    check("stream_instr", 64'(instr_o), 64'h100A);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("stream_drain", 64'(count_o), 64'd0);

    // Flush at cnt=2 drops entries and the same-cycle push
    out_ready_i = 1'b0;
    drive(1'b1, 32'h200, 32'h2000); step();
    drive(1'b1, 32'h204, 32'h2004); step();
    check("pre_flush_count", 64'(count_o), 64'd2);
    flush_i = 1'b1;
    drive(1'b1, 32'h208, 32'h2008);
    step();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_valid", 64'(out_valid_o), 64'd0);
    check("flush_instr", 64'(instr_o), 64'd0);
    check("flush_pc", 64'(pc_o), 64'd0);
    check("flush_ready", 64'(in_ready_o), 64'd1);
    step();
    check("flush_push_dropped", 64'(count_o), 64'd0);
    drive(1'b1, 32'h300, 32'h3000);
    step();
    check("post_flush_pc", 64'(pc_o), 64'h300);
    check("post_flush_count", 64'(count_o), 64'd1);

    // Stall blocks pop; pushes continue until full
    stall_i = 1'b1; out_ready_i = 1'b1;
    drive(1'b1, 32'h304, 32'h3004);
    step();
    check("stall_count", 64'(count_o), 64'd2);
    check("stall_pc", 64'(pc_o), 64'h300);
    check("stall_ready", 64'(in_ready_o), 64'd0);
    drive(1'b1, 32'h308, 32'h3008);
    step();
    check("stall_full_count", 64'(count_o), 64'd2);
    check("stall_full_pc", 64'(pc_o), 64'h300);
    stall_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("unstall_pc", 64'(pc_o), 64'h304);
    check("unstall_count", 64'(count_o), 64'd1);
    step();
    check("unstall_drain", 64'(count_o), 64'd0);

    // start_i low freezes state despite push, pop and flush requests
    out_ready_i = 1'b0;
    drive(1'b1, 32'h400, 32'h4000);
    step();
    start_i = 1'b0; out_ready_i = 1'b1; flush_i = 1'b1;
    drive(1'b1, 32'h404, 32'h4004);
    for (int i = 0; i < 3; i++) begin
      step();
      check("frozen_count", 64'(count_o), 64'd1);
      check("frozen_pc", 64'(pc_o), 64'h400);
    end
    flush_i = 1'b0;
    start_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("resume_pop", 64'(count_o), 64'd0);

    // Reset mid-operation discards entries
    out_ready_i = 1'b0;
    drive(1'b1, 32'h500, 32'h5000);
    step();
    drive(1'b0, 32'h0, 32'h0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("midrst_count", 64'(count_o), 64'd0);
    check("midrst_valid", 64'(out_valid_o), 64'd0);
    check("midrst_instr", 64'(instr_o), 64'd0);

`ifdef IF_ID_BUF_PERF_EN
    for (int i = 0; i < 4; i++) step();
    check("bubble_cnt", 64'(bubble_cnt_o), 64'd4);
    check("full_cnt_rst", 64'(full_cnt_o), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
